// File: rtl/i2c_pkg.sv
// Shared types and widths for the single-byte I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    SP_WAIT,
    SP_LOW,
    SP_HIGH
  } stop_ph_t;

  localparam int I2C_BYTE_BITS = 8;
  localparam int BAUD_W = 20;
  localparam int FREQ_W = 30;
  localparam int CNT_W = $clog2(I2C_BYTE_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(I2C_BYTE_BITS - 1);

endpackage

// File: rtl/i2c_master_controller_edge_detect.sv
// Registers the baud generator output once and flags its edges.
module i2c_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clock_i2c,
  output logic prev,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= clock_i2c;
  end

  assign rise = clock_i2c & ~prev;
  assign fall = ~clock_i2c & prev;

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK, STOP.
// Owns the baud generator configuration and enable.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 100_000
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [6:0]               Address,
  input  logic                     ReadWrite,
  input  logic [I2C_BYTE_BITS-1:0] DataIn,
  output logic [I2C_BYTE_BITS-1:0] DataOut,
  output logic                     Busy,
  output logic                     Done,
  output logic                     AckError,
  output logic                     BaudEnable,
  output logic [FREQ_W-1:0]        ClockFrequency,
  output logic [BAUD_W-1:0]        BaudRate,
  input  logic                     ClockI2C,
  output logic                     SCL,
  output logic                     SDAOut,
  input  logic                     SDAIn
);

  state_t                   state;
  stop_ph_t                 stop_ph;
  logic [I2C_BYTE_BITS-1:0] shreg;
  logic [I2C_BYTE_BITS-1:0] wdata;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     rw;
  logic                     sampled;
  logic                     prev;
  logic                     rise;
  logic                     fall;
  logic                     scl_en;
  logic                     rd_data;

  assign ClockFrequency = FREQ_W'(CLOCK_FREQUENCY);
  assign BaudRate       = BAUD_W'(BAUD_RATE);

  i2c_edge_detect u_edge (
    .clk       (clock),
    .rst_n     (Reset),
    .clock_i2c (ClockI2C),
    .prev      (prev),
    .rise      (rise),
    .fall      (fall)
  );

  // SCL follows the delayed generator until the STOP rise, then parks high
  assign scl_en = (state inside {ADDR, ADDR_ACK, DATA, DATA_ACK})
               || (state == STOP && stop_ph != SP_HIGH);
  assign SCL = scl_en ? prev : 1'b1;

  assign rd_data = (state == DATA) && rw;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      stop_ph    <= SP_WAIT;
      SDAOut     <= 1'b1;
      BaudEnable <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      AckError   <= 1'b0;
      DataOut    <= '0;
      shreg      <= '0;
      wdata      <= '0;
      bit_cnt    <= '0;
      rw         <= 1'b0;
      sampled    <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            shreg      <= {Address, ReadWrite};
            rw         <= ReadWrite;
            wdata      <= DataIn;
            AckError   <= 1'b0;
            BaudEnable <= 1'b1;
            Busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (rise) begin
            SDAOut  <= 1'b0;
            bit_cnt <= BIT_LAST;
            state   <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (fall) begin
            SDAOut <= rd_data ? 1'b1 : shreg[I2C_BYTE_BITS-1];
            shreg  <= shreg << 1;
          end
          if (rise) begin
            if (rd_data)
              DataOut <= {DataOut[I2C_BYTE_BITS-2:0], SDAIn};
            if (bit_cnt == '0) begin
              sampled <= 1'b0;
              state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // a read's data ACK slot is our own NACK, never an error
          if (rise) begin
            sampled <= 1'b1;
            if (SDAIn && !(state == DATA_ACK && rw))
              AckError <= 1'b1;
          end
          if (fall && !sampled)
            SDAOut <= 1'b1;
          if (fall && sampled) begin
            sampled <= 1'b0;
            if (state == DATA_ACK) begin
              SDAOut  <= 1'b0;
              stop_ph <= SP_LOW;
              state   <= STOP;
            end else if (AckError) begin
              stop_ph <= SP_WAIT;
              state   <= STOP;
            end else begin
              SDAOut  <= rw ? 1'b1 : wdata[I2C_BYTE_BITS-1];
              shreg   <= wdata << 1;
              bit_cnt <= BIT_LAST;
              state   <= DATA;
            end
          end
        end
        STOP: begin
          if (fall && stop_ph == SP_WAIT) begin
            SDAOut  <= 1'b0;
            stop_ph <= SP_LOW;
          end else if (rise && stop_ph == SP_LOW) begin
            stop_ph <= SP_HIGH;
          end else if (fall && stop_ph == SP_HIGH) begin
            SDAOut     <= 1'b1;
            BaudEnable <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            stop_ph    <= SP_WAIT;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Scoreboard bench: behavioural baud generator and I2C slave around the
// master, random and directed single-byte transactions.
module tb_i2c_master_controller;

  localparam int CF = 10;
  localparam int BR = 2;

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [6:0]  Address = '0;
  logic        ReadWrite = 1'b0;
  logic [7:0]  DataIn = '0;
  logic [7:0]  DataOut;
  logic        Busy, Done, AckError, BaudEnable;
  logic [29:0] ClockFrequency;
  logic [19:0] BaudRate;
  logic        ClockI2C;
  logic        SCL, SDAOut, SDAIn;

  always #5 clock = ~clock;

  i2c_master_controller #(
    .CLOCK_FREQUENCY (CF),
    .BAUD_RATE       (BR)
  ) dut (
    .clock          (clock),
    .Reset          (Reset),
    .Start          (Start),
    .Address        (Address),
    .ReadWrite      (ReadWrite),
    .DataIn         (DataIn),
    .DataOut        (DataOut),
    .Busy           (Busy),
    .Done           (Done),
    .AckError       (AckError),
    .BaudEnable     (BaudEnable),
    .ClockFrequency (ClockFrequency),
    .BaudRate       (BaudRate),
    .ClockI2C       (ClockI2C),
    .SCL            (SCL),
    .SDAOut         (SDAOut),
    .SDAIn          (SDAIn)
  );

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int dones = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud generator: square wave of ClockFrequency/BaudRate clocks per period
  int half;
  int gen_cnt;
  assign half = int'(ClockFrequency) / (2 * int'(BaudRate));

  always @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      gen_cnt  <= 0;
      ClockI2C <= 1'b0;
    end else if (!BaudEnable) begin
      gen_cnt  <= 0;
      ClockI2C <= 1'b0;
    end else if (gen_cnt >= half - 1) begin
      gen_cnt  <= 0;
      ClockI2C <= ~ClockI2C;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  // Slave configuration for the current transaction
  logic       sl_ack_addr = 1'b1;
  logic       sl_ack_data = 1'b1;
  logic [7:0] sl_rdata = '0;

  // Bus observer and slave, open-drain wired with the master
  logic       slave_low = 1'b0;
  logic       scl_q = 1'b1, sda_q = 1'b1, ci_q = 1'b0;
  logic       in_txn = 1'b0;
  logic       ack18 = 1'b1;
  logic [7:0] addr_obs = '0, data_obs = '0;
  int         rises = 0, stops = 0, ci_falls = 0, bus_viol = 0;

  assign SDAIn = SDAOut & ~slave_low;

  always @(negedge clock) begin : bus_mon
    int slot;
    if (!Reset) begin
      in_txn    <= 1'b0;
      slave_low <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      ci_q      <= 1'b0;
    end else begin
      scl_q <= SCL;
      sda_q <= SDAIn;
      ci_q  <= ClockI2C;
      if (ci_q && !ClockI2C)
        ci_falls <= ci_falls + 1;
      if (scl_q && SCL && (sda_q != SDAIn)) begin
        if (!SDAIn && !in_txn) begin
          in_txn   <= 1'b1;
          rises    <= 0;
          stops    <= 0;
          ci_falls <= 0;
          addr_obs <= '0;
          data_obs <= '0;
          ack18    <= 1'b1;
        end else if (SDAIn && in_txn) begin
          in_txn <= 1'b0;
          stops  <= stops + 1;
        end else begin
          bus_viol <= bus_viol + 1;
        end
      end
      if (!scl_q && SCL && in_txn) begin
        slot = rises + 1;
        rises <= slot;
        if (slot <= 8)
          addr_obs <= {addr_obs[6:0], SDAIn};
        else if (slot >= 10 && slot <= 17)
          data_obs <= {data_obs[6:0], SDAIn};
        else if (slot == 18)
          ack18 <= SDAIn;
      end
      if (scl_q && !SCL && in_txn) begin
        slot = rises + 1;
        if (slot == 9)
          slave_low <= sl_ack_addr;
        else if (slot >= 10 && slot <= 17)
          slave_low <= sl_ack_addr && addr_obs[0] && !sl_rdata[17 - slot];
        else if (slot == 18)
          slave_low <= sl_ack_addr && !addr_obs[0] && sl_ack_data;
        else
          slave_low <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0] addr_byte;
    logic       rw;
    logic       ack_addr;
    logic [7:0] data;
    logic       ack_err;
    int         falls;
    int         rises;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: compare every Done against the oldest expected transaction
  initial begin : monitor
    exp_t e;
    logic done_last;
    done_last = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (Reset) begin
        if (done_last)
          chk("done_width", Done, 0);
        if (Done) begin
          dones++;
          chk("pending_txn", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("addr_byte", addr_obs, e.addr_byte);
            chk("ack_error", AckError, e.ack_err);
            chk("falls_to_done", ci_falls, e.falls);
            chk("scl_rises", rises, e.rises);
            chk("stop_count", stops, 1);
            chk("bus_released", 32'(in_txn), 0);
            chk("bus_rules", bus_viol, 0);
            chk("busy_at_done", Busy, 0);
            chk("baud_off_at_done", BaudEnable, 0);
            chk("scl_at_done", SCL, 1);
            if (e.ack_addr)
              chk("data_bits", data_obs, e.data);
            if (e.ack_addr && e.rw) begin
              chk("data_out", DataOut, e.data);
              chk("master_nack", ack18, 1);
            end
          end
        end
      end
      done_last = Done && Reset;
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic r,
                         input logic [7:0] d, input logic ack_a,
                         input logic ack_d, input logic [7:0] rd,
                         input bit poke);
    exp_t e;
    int n;
    sl_ack_addr = ack_a;
    sl_ack_data = ack_d;
    sl_rdata    = rd;
    e.addr_byte = {a, r};
    e.rw        = r;
    e.ack_addr  = ack_a;
    e.data      = r ? rd : d;
    e.ack_err   = !ack_a || (!r && !ack_d);
    e.falls     = ack_a ? 20 : 12;
    e.rises     = ack_a ? 19 : 11;
    exp_q.push_back(e);
    issued++;
    @(posedge clock); #1;
    Address = a; ReadWrite = r; DataIn = d; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    chk("busy_after_start", Busy, 1);
    chk("baud_en_after_start", BaudEnable, 1);
    if (poke) begin
      repeat (8) @(posedge clock);
      #1;
      Address = ~a; ReadWrite = ~r; DataIn = ~d; Start = 1'b1;
      @(posedge clock); #1;
      Start = 1'b0;
      chk("busy_during_poke", Busy, 1);
    end
    n = 0;
    while (Busy && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk("txn_complete", Busy, 0);
    repeat (3) @(posedge clock);
  endtask

  task automatic reset_mid();
    int n;
    sl_ack_addr = 1'b1;
    sl_ack_data = 1'b1;
    sl_rdata    = '0;
    @(posedge clock); #1;
    Address = 7'h2B; ReadWrite = 1'b0; DataIn = 8'h96; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    n = 0;
    while (!(in_txn && rises >= 12) && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reach_data", 32'(in_txn && rises >= 12), 1);
    #2 Reset = 1'b0;
    #1;
    chk("rst_scl", SCL, 1);
    chk("rst_sda", SDAOut, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_baud_en", BaudEnable, 0);
    chk("rst_done", Done, 0);
    repeat (2) @(posedge clock);
    #1 Reset = 1'b1;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    #12;
    chk("reset_scl", SCL, 1);
    chk("reset_sda", SDAOut, 1);
    chk("reset_baud_en", BaudEnable, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_ack_error", AckError, 0);
    chk("reset_data_out", DataOut, 0);
    chk("clock_frequency", ClockFrequency, CF);
    chk("baud_rate", BaudRate, BR);
    #8 Reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_baud_en", BaudEnable, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_scl", SCL, 1);
    chk("idle_sda", SDAOut, 1);

    run_txn(7'h50, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0);
    run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0);
    run_txn(7'h50, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0);
    run_txn(7'h3C, 1'b0, 8'hE1, 1'b1, 1'b1, 8'h00, 1'b1);
    run_txn(7'h11, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00, 1'b0);
    reset_mid();
    chk("reset_cleared_ack", AckError, 0);
    chk("reset_cleared_data", DataOut, 0);
    for (int i = 0; i < 8; i++)
      run_txn(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 1'b0);
    run_txn(7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0);

    chk("done_count", dones, issued);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
